xy_waypoint_sequencer: RTL and testbench
========================================

XY_WAYPOINT_SEQUENCER -- requirements
Module: xy_waypoint_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, 8, number of waypoint entries (index width 3).
REQ-002 SHALL have parameter MOTION_CYCLES, 4, cycles motion is held high per waypoint issue.
REQ-003 SHALL have parameter SETTLE_CYCLES, 3, consecutive cycles pos==target required to declare arrival.
REQ-004 SHALL have parameter DWELL_CYCLES, 8, cycles held at a reached waypoint before advancing.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 255, maximum WAIT cycles before error.
REQ-006 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have wr_en / wr_addr[2:0] / wr_x[3:0] / wr_y[3:0]  inputs  waypoint table write port (BCD coordinates).
REQ-009 SHALL have last_idx  input  3  index of final waypoint in a run.
REQ-010 SHALL have start, abort, loop_en  inputs  1 each  run control.
REQ-011 SHALL have x_pos, y_pos  inputs  4 each  current BCD position returned by XY controller.
REQ-012 SHALL have target_x, target_y  outputs  4 each  BCD target presented to XY controller.
REQ-013 SHALL have motion  output  1  motion request to XY controller.
REQ-014 SHALL have busy, done, timeout_err, wr_err  outputs  1 each; cur_idx  output  3  active waypoint index.

Function
REQ-015 SHALL implement states IDLE, LOAD, ISSUE, WAIT, DWELL, DONE, ERR.
REQ-016 SHALL accept wr_en only in IDLE/DONE/ERR with wr_x<=9 and wr_y<=9; otherwise write ignored and wr_err pulses 1 cycle.
REQ-017 SHALL, on start sampled high in IDLE/DONE/ERR, enter LOAD next cycle with cur_idx=0, clearing done and timeout_err.
REQ-018 SHALL in LOAD (1 cycle) register table[cur_idx] into target_x/target_y, visible on entry to ISSUE.
REQ-019 SHALL in ISSUE drive motion=1 for exactly MOTION_CYCLES cycles, then enter WAIT with motion=0.
REQ-020 SHALL hold target_x/target_y stable from ISSUE entry until the next LOAD, abort, or reset.
REQ-021 SHALL in WAIT count consecutive cycles with x_pos==target_x and y_pos==target_y; any mismatch clears the count; count reaching SETTLE_CYCLES enters DWELL.
REQ-022 SHALL in WAIT increment an 8-bit timeout counter each cycle; reaching TIMEOUT_CYCLES before arrival enters ERR, sets timeout_err (sticky).
REQ-023 SHALL after DWELL_CYCLES in DWELL: if cur_idx!=last_idx, increment cur_idx and enter LOAD; if equal and loop_en=1, set cur_idx=0 and enter LOAD; else enter DONE.
REQ-024 SHALL hold done=1 in DONE until start or reset; busy=1 in LOAD/ISSUE/WAIT/DWELL only.
REQ-025 SHALL on abort in any busy state enter IDLE next cycle, motion=0, targets held, cur_idx held; abort has priority over start and all transitions.
REQ-026 SHALL treat start while busy as ignored.
REQ-027 SHALL treat a waypoint equal to current position as arriving after SETTLE_CYCLES in WAIT (no special case).
REQ-028 SHALL read table contents written before start; table unaffected by reset.

Reset
REQ-029 SHALL on reset enter IDLE: target_x=target_y=0, motion=0, busy=0, done=0, timeout_err=0, wr_err=0, cur_idx=0, all counters 0.
REQ-030 SHALL on reset mid-run abandon the run with no further motion pulse.

Structure
REQ-031 SHALL place state enum, BCD_MAX=9, and index width constant in shared package xy_seq_pkg.
REQ-032 SHALL implement the waypoint table as sub-module waypoint_ram (DEPTH x 8 bits, one write port, one registered read port).

Verification
REQ-033 SHALL test: table {(3,2),(0,5)}, last_idx=1, start, model controller tracks target -> targets 3/2 then 0/5, motion 4-cycle pulses, done=1.
REQ-034 SHALL test: pos never reaches target -> timeout_err=1 after 255 WAIT cycles, state ERR, motion=0.
REQ-035 SHALL test: wr_x=10 write and write while busy -> wr_err 1-cycle pulse, table unchanged.
REQ-036 SHALL test: loop_en=1, last_idx=1 -> after waypoint 1 cur_idx returns 0, targets 3/2 reissued, done stays 0.
REQ-037 SHALL test: abort during WAIT, and reset during ISSUE -> IDLE next cycle, motion=0, busy=0; reset also zeroes targets.
REQ-038 SHALL test: pos matches target for 2 cycles then glitches -> no DWELL entry until 3 consecutive matches.

Source files
------------

// File: rtl/xy_seq_pkg.sv
// Shared types and constants for the XY waypoint sequencer.
package xy_seq_pkg;

   localparam int         IDX_W   = 3;
   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_WAIT,
      ST_DWELL,
      ST_DONE,
      ST_ERR
   } seq_state_e;

   typedef struct packed {
      logic [BCD_W-1:0] x;
      logic [BCD_W-1:0] y;
   } waypoint_t;

   function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
      return d <= BCD_MAX;
   endfunction

endpackage

// File: rtl/waypoint_ram.sv
// Waypoint table: single write port, registered read port, no reset on contents.
module waypoint_ram #(
   parameter int DEPTH = 8,
   parameter int DW    = 8,
   parameter int AW    = 3
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/xy_waypoint_sequencer.sv
// Steps an XY controller through a table of BCD waypoints: issue, wait for
// settled arrival (with timeout), dwell, advance or loop.
module xy_waypoint_sequencer
   import xy_seq_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int MOTION_CYCLES  = 4,
   parameter int SETTLE_CYCLES  = 3,
   parameter int DWELL_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_addr_i,
   input  logic [BCD_W-1:0] wr_x_i,
   input  logic [BCD_W-1:0] wr_y_i,
   input  logic [IDX_W-1:0] last_idx_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             loop_en_i,
   input  logic [BCD_W-1:0] x_pos_i,
   input  logic [BCD_W-1:0] y_pos_i,
   output logic [BCD_W-1:0] target_x_o,
   output logic [BCD_W-1:0] target_y_o,
   output logic             motion_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_err_o,
   output logic             wr_err_o,
   output logic [IDX_W-1:0] cur_idx_o
);

   localparam logic [7:0] MOTION_LAST  = 8'(MOTION_CYCLES - 1);
   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] DWELL_LAST   = 8'(DWELL_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   seq_state_e       state_q, state_d;
   logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
   logic [BCD_W-1:0] tx_q, tx_d, ty_q, ty_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       settle_q, settle_d;
   logic [7:0]       tmo_q, tmo_d;
   logic             terr_q, terr_d;
   logic             wr_err_q, wr_err_d;

   logic             busy, wr_ok, at_target;
   logic [7:0]       rd_data;
   waypoint_t        rd_wp;

   assign busy      = state_q inside {ST_LOAD, ST_ISSUE, ST_WAIT, ST_DWELL};
   assign wr_ok     = !busy && bcd_ok(wr_x_i) && bcd_ok(wr_y_i);
   assign at_target = (x_pos_i == tx_q) && (y_pos_i == ty_q);
   assign rd_wp     = rd_data;

   // Read address follows the next index so the entry is ready during LOAD.
   waypoint_ram #(
      .DEPTH (DEPTH),
      .DW    (2 * BCD_W),
      .AW    (IDX_W)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (wr_en_i && wr_ok),
      .waddr_i (wr_addr_i),
      .wdata_i ({wr_x_i, wr_y_i}),
      .raddr_i (cur_idx_d),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         cur_idx_q <= '0;
         tx_q      <= '0;
         ty_q      <= '0;
         cnt_q     <= '0;
         settle_q  <= '0;
         tmo_q     <= '0;
         terr_q    <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_idx_q <= cur_idx_d;
         tx_q      <= tx_d;
         ty_q      <= ty_d;
         cnt_q     <= cnt_d;
         settle_q  <= settle_d;
         tmo_q     <= tmo_d;
         terr_q    <= terr_d;
         wr_err_q  <= wr_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_idx_d = cur_idx_q;
      tx_d      = tx_q;
      ty_d      = ty_q;
      cnt_d     = cnt_q;
      settle_d  = settle_q;
      tmo_d     = tmo_q;
      terr_d    = terr_q;
      wr_err_d  = wr_en_i && !wr_ok;

      if (busy && abort_i) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         settle_d = '0;
         tmo_d    = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start_i) begin
                  state_d   = ST_LOAD;
                  cur_idx_d = '0;
                  terr_d    = 1'b0;
               end
            end
            ST_LOAD: begin
               tx_d    = rd_wp.x;
               ty_d    = rd_wp.y;
               cnt_d   = '0;
               state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
               if (cnt_q == MOTION_LAST) begin
                  state_d  = ST_WAIT;
                  cnt_d    = '0;
                  settle_d = '0;
                  tmo_d    = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            ST_WAIT: begin
               tmo_d    = tmo_q + 8'd1;
               settle_d = at_target ? settle_q + 8'd1 : 8'd0;
               // Arrival wins over timeout when both land on the same cycle.
               if (at_target && settle_q == SETTLE_LAST) begin
                  state_d = ST_DWELL;
                  cnt_d   = '0;
               end else if (tmo_q == TIMEOUT_LAST) begin
                  state_d = ST_ERR;
                  terr_d  = 1'b1;
               end
            end
            ST_DWELL: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_d = '0;
                  if (cur_idx_q != last_idx_i) begin
                     cur_idx_d = cur_idx_q + 3'd1;
                     state_d   = ST_LOAD;
                  end else if (loop_en_i) begin
                     cur_idx_d = '0;
                     state_d   = ST_LOAD;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign target_x_o    = tx_q;
   assign target_y_o    = ty_q;
   assign motion_o      = (state_q == ST_ISSUE);
   assign busy_o        = busy;
   assign done_o        = (state_q == ST_DONE);
   assign timeout_err_o = terr_q;
   assign wr_err_o      = wr_err_q;
   assign cur_idx_o     = cur_idx_q;

endmodule

// File: tb/tb_xy_waypoint_sequencer.sv
// Directed bench for the waypoint sequencer with a cycle-level behavioural
// reference checked every cycle, plus hand-computed milestone checks.
module tb_xy_waypoint_sequencer;

   localparam int MOT = 4;
   localparam int SET = 3;
   localparam int DWL = 8;
   localparam int TMO = 255;

   logic       clk = 1'b0;
   logic       reset, wr_en, start, abort, loop_en;
   logic [2:0] wr_addr, last_idx, cur_idx;
   logic [3:0] wr_x, wr_y, x_pos, y_pos, target_x, target_y;
   logic       motion, busy, done, timeout_err, wr_err;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int ctrl_mode = 0;  // 0 driven by test, 1 tracks target, 2 parked off-target

   xy_waypoint_sequencer dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .wr_en_i       (wr_en),
      .wr_addr_i     (wr_addr),
      .wr_x_i        (wr_x),
      .wr_y_i        (wr_y),
      .last_idx_i    (last_idx),
      .start_i       (start),
      .abort_i       (abort),
      .loop_en_i     (loop_en),
      .x_pos_i       (x_pos),
      .y_pos_i       (y_pos),
      .target_x_o    (target_x),
      .target_y_o    (target_y),
      .motion_o      (motion),
      .busy_o        (busy),
      .done_o        (done),
      .timeout_err_o (timeout_err),
      .wr_err_o      (wr_err),
      .cur_idx_o     (cur_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_LOAD, M_ISSUE, M_WAIT, M_DWELL, M_DONE, M_ERR} mphase_t;
   mphase_t ph = M_IDLE;
   int      m_idx = 0, m_tx = 0, m_ty = 0, m_el = 0;
   bit      m_terr = 1'b0, m_wrerr = 1'b0;
   int      tbl_x [8];
   int      tbl_y [8];
   bit      hist [$];

   function automatic bit m_busy(input mphase_t p);
      return p == M_LOAD || p == M_ISSUE || p == M_WAIT || p == M_DWELL;
   endfunction

   always @(posedge clk) begin : model
      bit hit;
      m_wrerr = 1'b0;
      if (reset) begin
         ph = M_IDLE; m_idx = 0; m_tx = 0; m_ty = 0; m_el = 0; m_terr = 1'b0;
         hist.delete();
      end else begin
         if (wr_en) begin
            if (!m_busy(ph) && wr_x <= 9 && wr_y <= 9) begin
               tbl_x[wr_addr] = int'(wr_x);
               tbl_y[wr_addr] = int'(wr_y);
            end else m_wrerr = 1'b1;
         end
         if (m_busy(ph) && abort) ph = M_IDLE;
         else begin
            case (ph)
               M_IDLE, M_DONE, M_ERR:
                  if (start) begin ph = M_LOAD; m_idx = 0; m_terr = 1'b0; end
               M_LOAD: begin
                  m_tx = tbl_x[m_idx]; m_ty = tbl_y[m_idx]; m_el = 0; ph = M_ISSUE;
               end
               M_ISSUE: begin
                  m_el++;
                  if (m_el == MOT) begin ph = M_WAIT; m_el = 0; hist.delete(); end
               end
               M_WAIT: begin
                  m_el++;
                  hist.push_back(int'(x_pos) == m_tx && int'(y_pos) == m_ty);
                  hit = hist.size() >= SET;
                  for (int i = 0; i < SET; i++)
                     if (hit && !hist[hist.size() - 1 - i]) hit = 1'b0;
                  if (hit) begin ph = M_DWELL; m_el = 0; end
                  else if (m_el == TMO) begin ph = M_ERR; m_terr = 1'b1; end
               end
               M_DWELL: begin
                  m_el++;
                  if (m_el == DWL) begin
                     m_el = 0;
                     if (m_idx != int'(last_idx)) begin m_idx++; ph = M_LOAD; end
                     else if (loop_en) begin m_idx = 0; ph = M_LOAD; end
                     else ph = M_DONE;
                  end
               end
               default: ph = M_IDLE;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("motion",      32'(motion),      32'(ph == M_ISSUE));
         check("busy",        32'(busy),        32'(m_busy(ph)));
         check("done",        32'(done),        32'(ph == M_DONE));
         check("timeout_err", 32'(timeout_err), 32'(m_terr));
         check("wr_err",      32'(wr_err),      32'(m_wrerr));
         check("cur_idx",     32'(cur_idx),     m_idx);
         check("target_x",    32'(target_x),    m_tx);
         check("target_y",    32'(target_y),    m_ty);
      end
   end

   // XY controller stand-in
   always @(posedge clk) begin
      #1;
      if (ctrl_mode == 1) begin x_pos = target_x; y_pos = target_y; end
      else if (ctrl_mode == 2) begin x_pos = 4'd9; y_pos = 4'd9; end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic write_wp(input int a, input int x, input int y);
      wr_en = 1'b1; wr_addr = 3'(a); wr_x = 4'(x); wr_y = 4'(y);
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int n, npulse, run, mcnt;
      int plen [2];
      int ptx [2];
      int pty [2];

      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
      last_idx = '0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
      x_pos = '0; y_pos = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_target_x", 32'(target_x), 0);
      check("rst_target_y", 32'(target_y), 0);
      check("rst_motion",   32'(motion), 0);
      check("rst_busy",     32'(busy), 0);
      check("rst_done",     32'(done), 0);
      check("rst_terr",     32'(timeout_err), 0);
      check("rst_cur_idx",  32'(cur_idx), 0);
      reset = 1'b0;

      write_wp(0, 3, 2);
      write_wp(1, 0, 5);

      // two-waypoint run, controller tracks the target
      last_idx = 3'd1; ctrl_mode = 1;
      pulse_start();
      n = 0; npulse = 0; run = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1; n++;
         if (motion) begin
            if (run == 0 && npulse < 2) begin
               ptx[npulse] = int'(target_x); pty[npulse] = int'(target_y);
            end
            run++;
         end else if (run > 0) begin
            if (npulse < 2) plen[npulse] = run;
            npulse++; run = 0;
         end
      end
      check("t1_cycles_to_done", n, 32);
      check("t1_pulses", npulse, 2);
      check("t1_pulse0_len", plen[0], 4);
      check("t1_pulse1_len", plen[1], 4);
      check("t1_tgt0_x", ptx[0], 3);
      check("t1_tgt0_y", pty[0], 2);
      check("t1_tgt1_x", ptx[1], 0);
      check("t1_tgt1_y", pty[1], 5);
      check("t1_done", 32'(done), 1);

      // illegal BCD writes
      wr_en = 1'b1; wr_addr = 3'd0; wr_x = 4'd10; wr_y = 4'd1;
      @(posedge clk); #1;
      wr_en = 1'b0;
      check("t3_badx_wrerr", 32'(wr_err), 1);
      @(posedge clk); #1;
      check("t3_wrerr_1cyc", 32'(wr_err), 0);
      write_wp(1, 1, 12);
      check("t3_bady_wrerr", 32'(wr_err), 1);

      // looping run, write while busy, then abort in WAIT
      loop_en = 1'b1; last_idx = 3'd1; ctrl_mode = 1;
      pulse_start();
      for (int k = 1; k <= 41; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            check("t4_first_tx", 32'(target_x), 3);
            check("t4_first_ty", 32'(target_y), 2);
         end
         if (k == 2) begin wr_en = 1'b1; wr_addr = 3'd0; wr_x = 4'd7; wr_y = 4'd7; end
         if (k == 3) begin wr_en = 1'b0; check("t4_busy_wrerr", 32'(wr_err), 1); end
         if (k == 4) check("t4_busy_wrerr_1cyc", 32'(wr_err), 0);
         if (k == 20) check("t4_idx1", 32'(cur_idx), 1);
         if (k == 33) begin
            check("t4_loop_idx0", 32'(cur_idx), 0);
            check("t4_loop_tx",   32'(target_x), 3);
            check("t4_loop_ty",   32'(target_y), 2);
            check("t4_loop_motion", 32'(motion), 1);
            check("t4_loop_done", 32'(done), 0);
            ctrl_mode = 2;
         end
         if (k == 40) abort = 1'b1;
         if (k == 41) begin
            abort = 1'b0;
            check("t5_abort_busy",   32'(busy), 0);
            check("t5_abort_motion", 32'(motion), 0);
            check("t5_abort_tx",     32'(target_x), 3);
            check("t5_abort_done",   32'(done), 0);
         end
      end
      loop_en = 1'b0;

      // reset while in ISSUE
      ctrl_mode = 1; last_idx = 3'd1;
      pulse_start();
      @(posedge clk); #1;
      check("t5_issue_motion", 32'(motion), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("t5_rst_motion", 32'(motion), 0);
      check("t5_rst_busy",   32'(busy), 0);
      check("t5_rst_tx",     32'(target_x), 0);
      check("t5_rst_ty",     32'(target_y), 0);
      mcnt = 0;
      repeat (10) begin @(posedge clk); #1; if (motion) mcnt++; end
      check("t5_no_more_motion", mcnt, 0);

      // timeout: position never reaches target
      ctrl_mode = 2; last_idx = 3'd0;
      pulse_start();
      n = 0;
      while (!timeout_err && n < 400) begin @(posedge clk); #1; n++; end
      check("t2_cycles_to_err", n, 260);
      check("t2_err_motion", 32'(motion), 0);
      check("t2_err_busy",   32'(busy), 0);
      check("t2_err_done",   32'(done), 0);

      // settle glitch: two matches, a miss, then three matches
      ctrl_mode = 0; x_pos = 4'd4; y_pos = 4'd2;
      pulse_start();
      check("t6_terr_cleared", 32'(timeout_err), 0);
      n = 0;
      while (!done && n < 60) begin
         @(posedge clk); #1; n++;
         if (n == 3) start = 1'b1;
         if (n == 4) start = 1'b0;
         x_pos = (n == 5 || n == 6 || n >= 8) ? 4'd3 : 4'd4;
      end
      check("t6_cycles_to_done", n, 19);

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
